// File: rtl/counter_74x161.sv
// counter_74x161: presettable binary counter with ripple-carry cascade output.
// Defining CNT_UPDOWN_EN adds the UP input for down counting (terminal 0 for RCO).
module counter_74x161 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
`ifdef CNT_UPDOWN_EN
  input  logic             UP,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);
  localparam logic [WIDTH-1:0] ONE = 1;
  logic [WIDTH-1:0] q_q, q_d;
  logic up;
`ifdef CNT_UPDOWN_EN
  assign up = UP;
`else
  assign up = 1'b1;
`endif
  always_comb begin
    q_d = !LOAD_N ? D : (ENP && ENT) ? (up ? q_q + ONE : q_q - ONE) : q_q;
  end
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) q_q <= '0;
    else        q_q <= q_d;
  end
  assign Q   = q_q;
  assign RCO = ENT && (q_q == (up ? {WIDTH{1'b1}} : {WIDTH{1'b0}}));
endmodule

// File: tb/tb_counter_74x161.sv
// tb_counter_74x161: randomized and directed checks against an arithmetic counter model,
// plus a two-stage cascade treated as one 8-bit counter.
module tb_counter_74x161;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 0, clr_n = 0, load_n = 1, enp = 0, ent = 0, up = 1;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic rco;
  logic c_load_n = 1;
  logic [7:0] cd = '0;
  logic [3:0] lq, hq;
  logic lrco, hrco;
  int errors = 0, checks = 0, mq = 0, cm = 0;

  always #5 clk = ~clk;

  counter_74x161 #(.WIDTH(W)) dut (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent), .D(d),
`ifdef CNT_UPDOWN_EN
    .UP(up),
`endif
    .Q(q), .RCO(rco));

  counter_74x161 #(.WIDTH(4)) lo (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(1'b1), .ENT(1'b1), .D(cd[3:0]),
`ifdef CNT_UPDOWN_EN
    .UP(1'b1),
`endif
    .Q(lq), .RCO(lrco));

  counter_74x161 #(.WIDTH(4)) hi (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(1'b1), .ENT(lrco), .D(cd[7:4]),
`ifdef CNT_UPDOWN_EN
    .UP(1'b1),
`endif
    .Q(hq), .RCO(hrco));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_rco();
    return (ent && mq == (up ? M - 1 : 0)) ? 1 : 0;
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (!clr_n) mq = 0;
    else if (!load_n) mq = int'(d);
    else if (enp && ent) mq = (mq + (up ? 1 : M - 1)) % M;
    check({tag, "_q"}, int'(q), mq);
    check({tag, "_rco"}, int'(rco), exp_rco());
  endtask

  task automatic load(input int v);
    load_n = 0;
    d = W'(v);
    tick("load");
    load_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      d = W'($urandom); load_n = 1'($urandom); enp = 1'($urandom); ent = 1'($urandom);
      tick("reset");
    end
    clr_n = 1;
    load_n = 1; enp = 1; ent = 1;
    for (int i = 0; i < 17; i++) tick("count");
    load(8);
    tick("to9");
    #2 clr_n = 0;
    #1 mq = 0;
    check("async_clr_q", int'(q), 0);
    check("async_clr_rco", int'(rco), 0);
    tick("held_clr");
    clr_n = 1;
    load(3);
    load_n = 0; d = 12; enp = 1; ent = 1;
    tick("load_prio");
    d = 5; enp = 0; ent = 0;
    tick("load_noen");
    load(7);
    enp = 0; ent = 1;
    tick("enp_hold");
    load(15);
    enp = 1; ent = 0;
    tick("ent_hold");
    ent = 1;
    #1;
    check("rco_comb", int'(rco), 1);
    for (int i = 0; i < 150; i++) begin
      load_n = ($urandom_range(0, 5) != 0);
      enp = ($urandom_range(0, 3) != 0);
      ent = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
`ifdef CNT_UPDOWN_EN
      up = 1'($urandom);
`endif
      tick("rand");
    end
    up = 1;
`ifdef CNT_UPDOWN_EN
    load(2);
    up = 0; enp = 1; ent = 1;
    for (int i = 0; i < 4; i++) tick("down");
    load(0);
    check("down_rco0", int'(rco), 1);
    up = 1;
    #1;
    check("up_rco_drop", int'(rco), 0);
`endif
    c_load_n = 0; cd = 8'h0E; cm = 8'h0E;
    @(posedge clk);
    #1;
    c_load_n = 1;
    check("casc_load", int'({hq, lq}), cm);
    for (int i = 1; i <= 242; i++) begin
      @(posedge clk);
      #1;
      cm = (cm + 1) % 256;
      if (i % 16 == 2 || i == 242) check("casc", int'({hq, lq}), cm);
    end
    check("casc_wrap", int'({hq, lq}), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
